// File: rtl/img_pkg.sv
`default_nettype none
// ============================================================================
// Module   : img_pkg
// Purpose  : Shared constants and loader state type for the image frame
//            loader and its byte packer.
// Revision : 1.0 - initial release
// ============================================================================
package img_pkg;

  localparam int IMG_BYTES   = 1024;
  localparam int WORD_BYTES  = 16;
  localparam int FRAME_WORDS = IMG_BYTES / WORD_BYTES;

  // Width of the RAM word address and of the byte-lane index.
  localparam int ADDR_W      = 8;
  localparam int BYTE_IDX_W  = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/img_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : img_byte_packer
// Purpose  : Packs accepted bytes little-endian into a wide word. Holds the
//            byte-lane index and the lane register; upper lanes keep stale
//            data until overwritten.
// Revision : 1.0 - initial release
// ============================================================================
module img_byte_packer #(
  parameter int WORD_BYTES = img_pkg::WORD_BYTES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr_i,
  input  logic                    accept_i,
  input  logic [7:0]              byte_i,
  output logic [8*WORD_BYTES-1:0] dw_o,
  output logic                    last_o
);

  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [8*WORD_BYTES-1:0] dw_q, dw_d;

  // The accepted byte completes the word when it lands in the top lane.
  assign last_o = accept_i && (idx_q == LAST_IDX);
  assign dw_o   = dw_q;

  // Next lane index and lane contents.
  always_comb begin
    idx_d = idx_q;
    dw_d  = dw_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (accept_i) begin
      dw_d[{idx_q, 3'b000} +: 8] = byte_i;
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Lane index and word register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
      dw_q  <= '0;
    end else begin
      idx_q <= idx_d;
      dw_q  <= dw_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/img_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : img_frame_loader
// Purpose  : Loads one image frame from a byte stream into the image RAM as
//            FRAME_WORDS wide words. Four-state FSM: IDLE, FILL, WRITE, DONE.
//            All strobes are decoded from the registered state.
// Revision : 1.0 - initial release
// ============================================================================
module img_frame_loader #(
  parameter int WORD_BYTES  = img_pkg::WORD_BYTES,
  parameter int FRAME_WORDS = img_pkg::FRAME_WORDS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [7:0]                 byte_in,
  input  logic                       byte_valid,
  output logic                       byte_ready,
  output logic [8*WORD_BYTES-1:0]    dw,
  output logic [img_pkg::ADDR_W-1:0] addr_w,
  output logic                       write,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 frame_cnt
);

  import img_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              start_go;
  logic              accept;
  logic              word_full;

  // A start only counts in IDLE and loses to a simultaneous abort.
  assign start_go = (state_q == S_IDLE) && start && !abort;
  assign accept   = (state_q == S_FILL) && byte_valid;

  img_byte_packer #(
    .WORD_BYTES (WORD_BYTES)
  ) u_packer (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (start_go),
    .accept_i (accept),
    .byte_i   (byte_in),
    .dw_o     (dw),
    .last_o   (word_full)
  );

  // Next state, address, frame counter, and state-decoded strobes.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    byte_ready = (state_q == S_FILL);
    write      = (state_q == S_WRITE);
    done       = (state_q == S_DONE);
    busy       = (state_q != S_IDLE);
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_FILL;
            addr_d  = '0;
          end
        end
        S_FILL: begin
          if (word_full) state_d = S_WRITE;
        end
        S_WRITE: begin
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_FILL;
          end
        end
        S_DONE: begin
          cnt_d   = cnt_q + 8'd1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, address and frame-count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign addr_w    = addr_q;
  assign frame_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_img_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_img_frame_loader
// Purpose  : Self-checking bench for img_frame_loader. A byte scoreboard
//            packs every byte handed over and compares each RAM write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_img_frame_loader;

  localparam int WB = 16;
  localparam int FW = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         start2 = 1'b0;
  logic [7:0]   byte_in = 8'h00;
  logic         byte_valid = 1'b0;
  logic         byte_ready, write, busy, done;
  logic [127:0] dw;
  logic [7:0]   addr_w, frame_cnt;
  logic         byte_ready2, write2, busy2, done2;
  logic [127:0] dw2;
  logic [7:0]   addr_w2, frame_cnt2;

  always #5 clk = ~clk;

  img_frame_loader #(.WORD_BYTES(WB), .FRAME_WORDS(FW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .dw(dw), .addr_w(addr_w), .write(write), .busy(busy), .done(done),
    .frame_cnt(frame_cnt)
  );

  // Short-frame instance for the frame counter wrap.
  img_frame_loader #(.WORD_BYTES(WB), .FRAME_WORDS(2)) dut_small (
    .clk(clk), .reset(reset), .start(start2), .abort(1'b0),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready2),
    .dw(dw2), .addr_w(addr_w2), .write(write2), .busy(busy2), .done(done2),
    .frame_cnt(frame_cnt2)
  );

  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  logic [7:0]   byteq[$];
  int           byte_ctr = 0;
  int           exp_word = 0;
  int           n_writes = 0;
  int           n_done2 = 0;
  bit           gap_mode = 0;
  bit           first_wr = 0;
  int           first_wr_addr = -1;
  bit           done_seen = 0;
  int           done_cyc = 0;
  logic [127:0] word0_dw = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: observe outputs at negedge, then drive the next byte.
  task automatic tick();
    logic [127:0] exp_dw;
    @(negedge clk);
    cyc++;
    if (write) begin
      n_writes++;
      if (first_wr) begin
        first_wr_addr = addr_w;
        first_wr = 0;
      end
      if (exp_word == 0) word0_dw = dw;
      chk("wr_addr", {120'd0, addr_w}, 128'(exp_word));
      if (byteq.size() < WB) begin
        chk("wr_underflow", 128'(byteq.size()), 128'(WB));
      end else begin
        exp_dw = '0;
        for (int j = 0; j < WB; j++) exp_dw[8*j +: 8] = byteq.pop_front();
        chk("wr_dw", dw, exp_dw);
      end
      exp_word++;
    end
    if (done) begin
      done_seen = 1;
      done_cyc  = cyc;
    end
    if (done2) n_done2++;
    byte_valid = gap_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    byte_in    = byte_valid ? byte_ctr[7:0] : 8'($urandom);
    if (byte_valid && byte_ready) begin
      byteq.push_back(byte_in);
      byte_ctr++;
    end
  endtask

  task automatic model_start();
    byteq.delete();
    byte_ctr  = 0;
    exp_word  = 0;
    n_writes  = 0;
    first_wr  = 1;
    done_seen = 0;
  endtask

  // Full frame from IDLE; lat = cycles from the start-drive point to done.
  task automatic run_frame(input bit gaps, input bit mid_start, output int lat);
    int c0;
    gap_mode = gaps;
    chk("ready_idle", {127'd0, byte_ready}, 128'd0);
    model_start();
    c0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ready_rise", {127'd0, byte_ready}, 128'd1);
    for (int i = 0; i < 6000 && !done_seen; i++) begin
      start = mid_start && (i == 300);
      tick();
      start = 1'b0;
    end
    chk("frame_timeout", {127'd0, done_seen}, 128'd1);
    lat = done_cyc - c0;
    tick();
    chk("frame_writes", 128'(n_writes), 128'(FW));
    chk("idle_busy", {127'd0, busy}, 128'd0);
    chk("addr_hold", {120'd0, addr_w}, 128'(FW - 1));
  endtask

  initial begin
    int lat;
    int guard;
    // Reset state.
    #2;
    chk("rst_busy",  {127'd0, busy}, 128'd0);
    chk("rst_write", {127'd0, write}, 128'd0);
    chk("rst_done",  {127'd0, done}, 128'd0);
    chk("rst_ready", {127'd0, byte_ready}, 128'd0);
    chk("rst_dw",    dw, 128'd0);
    chk("rst_addr",  {120'd0, addr_w}, 128'd0);
    chk("rst_fcnt",  {120'd0, frame_cnt}, 128'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Back-to-back bytes: latency (start cycle through done cycle = 1090).
    run_frame(0, 0, lat);
    chk("latency", 128'(lat + 1), 128'd1090);
    chk("word0", word0_dw, 128'h0F0E0D0C0B0A09080706050403020100);
    chk("fcnt1", {120'd0, frame_cnt}, 128'd1);

    // 50% valid gaps: scoreboard checks identical word sequence.
    run_frame(1, 0, lat);
    chk("fcnt2", {120'd0, frame_cnt}, 128'd2);
    gap_mode = 0;

    // Abort while filling word 5.
    model_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!(exp_word == 5 && byteq.size() >= 3) && guard < 2000) begin
      tick();
      guard++;
    end
    chk("abort_reach", {127'd0, (guard < 2000)}, 128'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    byteq.delete();
    chk("abort_busy",   {127'd0, busy}, 128'd0);
    chk("abort_fcnt",   {120'd0, frame_cnt}, 128'd2);
    chk("abort_writes", 128'(n_writes), 128'd5);
    chk("abort_done",   {127'd0, done_seen}, 128'd0);

    // Restart after abort, with a stray start mid-frame.
    run_frame(0, 1, lat);
    chk("restart_addr0", 128'(first_wr_addr), 128'd0);
    chk("busy_start_lat", 128'(lat + 1), 128'd1090);
    chk("fcnt3", {120'd0, frame_cnt}, 128'd3);

    // start and abort together in IDLE.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy0", {127'd0, busy}, 128'd0);
    tick();
    chk("sa_busy1", {127'd0, busy}, 128'd0);

    // 256 short frames: counter wraps to zero.
    n_done2 = 0;
    for (int f = 0; f < 256; f++) begin
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      guard = 0;
      while (busy2 && guard < 200) begin
        tick();
        guard++;
      end
      if (f == 0) chk("small_fcnt1", {120'd0, frame_cnt2}, 128'd1);
      if (guard >= 200) chk("small_timeout", 128'(guard), 128'd0);
    end
    chk("wrap_done_cnt", 128'(n_done2), 128'd256);
    chk("wrap_fcnt", {120'd0, frame_cnt2}, 128'd0);

    // Reset asserted while in WRITE.
    model_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!write && guard < 100) begin
      tick();
      guard++;
    end
    chk("reach_write", {127'd0, write}, 128'd1);
    reset = 1'b1;
    #1;
    chk("wrst_write", {127'd0, write}, 128'd0);
    chk("wrst_busy",  {127'd0, busy}, 128'd0);
    chk("wrst_ready", {127'd0, byte_ready}, 128'd0);
    chk("wrst_done",  {127'd0, done}, 128'd0);
    chk("wrst_dw",    dw, 128'd0);
    chk("wrst_addr",  {120'd0, addr_w}, 128'd0);
    chk("wrst_fcnt",  {120'd0, frame_cnt}, 128'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_busy", {127'd0, busy}, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
